hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: computes the F/D stall, E-stage bubble and

---
 rtl/hazard_pkg.sv | 49 ++++
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/md_sched.sv | 67 ++++++
 rtl/hazard_ctrl.sv | 49 ++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared constants, encodings and hazard helper functions for the pipeline sequencer.
// Tuse/Tnew values are cycle counts; select codes drive the forwarding muxes directly.
package hazard_pkg;

   localparam logic [1:0] TUSE_NONE = 2'd3;
   localparam logic [1:0] TNEW_0    = 2'd0;

   // D-stage operand sources
   localparam logic [1:0] FWD_GRF   = 2'd0;
   localparam logic [1:0] FWD_E     = 2'd1;
   localparam logic [1:0] FWD_M     = 2'd2;

   // E-stage operand sources
   localparam logic [1:0] FWD_ID2EX = 2'd0;
   localparam logic [1:0] FWD_EM    = 2'd1;
   localparam logic [1:0] FWD_W     = 2'd2;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   function automatic logic raw_stall(logic [4:0] adr, logic [1:0] tuse,
                                      logic [4:0] e_adr, logic [1:0] e_tnew,
                                      logic [4:0] m_adr, logic [1:0] m_tnew);
      return (adr != 5'd0) && (tuse != TUSE_NONE) &&
             (((adr == e_adr) && (e_tnew > tuse)) || ((adr == m_adr) && (m_tnew > tuse)));
   endfunction

   // Youngest producer wins
   function automatic logic [1:0] fwd_d_sel(logic [4:0] adr,
                                            logic [4:0] e_adr, logic [1:0] e_tnew,
                                            logic [4:0] m_adr, logic [1:0] m_tnew);
      if (adr == 5'd0) return FWD_GRF;
      if ((adr == e_adr) && (e_tnew == TNEW_0)) return FWD_E;
      if ((adr == m_adr) && (m_tnew == TNEW_0)) return FWD_M;
      return FWD_GRF;
   endfunction

   function automatic logic [1:0] fwd_e_sel(logic [4:0] adr,
                                            logic [4:0] m_adr, logic [1:0] m_tnew,
                                            logic [4:0] w_adr);
      if (adr == 5'd0) return FWD_ID2EX;
      if ((adr == m_adr) && (m_tnew == TNEW_0)) return FWD_EM;
      if (adr == w_adr) return FWD_W;
      return FWD_ID2EX;
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-to-sequencer bundle: register-use timing and mult/div requests in,
// stall/flush, forwarding selects and mult/div status out.
interface hazard_ctrl_if;
   logic [4:0] D_rs_adr;
   logic [4:0] D_rt_adr;
   logic [1:0] D_tuse_rs;
   logic [1:0] D_tuse_rt;
   logic       D_md_use;
   logic [4:0] E_wr_adr;
   logic [1:0] E_tnew;
   logic [4:0] M_wr_adr;
   logic [1:0] M_tnew;
   logic [4:0] W_wr_adr;
   logic [4:0] E_rs_adr;
   logic [4:0] E_rt_adr;
   logic       E_md_start;
   logic       E_md_div;
   logic       stall;
   logic       flush_E;
   logic [1:0] fwd_D_rs;
   logic [1:0] fwd_D_rt;
   logic [1:0] fwd_E_rs;
   logic [1:0] fwd_E_rt;
   logic       md_busy;
   logic       md_done;

   modport master (
      output D_rs_adr, D_rt_adr, D_tuse_rs, D_tuse_rt, D_md_use,
      output E_wr_adr, E_tnew, M_wr_adr, M_tnew, W_wr_adr,
      output E_rs_adr, E_rt_adr, E_md_start, E_md_div,
      input  stall, flush_E, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy, md_done
   );

   modport slave (
      input  D_rs_adr, D_rt_adr, D_tuse_rs, D_tuse_rt, D_md_use,
      input  E_wr_adr, E_tnew, M_wr_adr, M_tnew, W_wr_adr,
      input  E_rs_adr, E_rt_adr, E_md_start, E_md_div,
      output stall, flush_E, fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, md_busy, md_done
   );
endinterface

// File: rtl/md_sched.sv
// Mult/div occupancy scheduler: busy for exactly N cycles after a start, done pulses on the
// last busy cycle. A start in the done cycle reloads without a gap.
module md_sched
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic is_div,
   output logic busy,
   output logic done
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
   localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

   md_state_e       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] load_val;

   assign load_val = is_div ? DivLoad : MultLoad;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy    = (state_q == MD_BUSY);
      done    = 1'b0;
      unique case (state_q)
         MD_IDLE: begin
            if (start) begin
               state_d = MD_BUSY;
               cnt_d   = load_val;
            end
         end
         MD_BUSY: begin
            if (cnt_q == '0) begin
               // An operation aborted by reset never reports completion
               done = ~reset;
               if (start) begin
                  cnt_d = load_val;
               end else begin
                  state_d = MD_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = MD_IDLE;
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: Tuse/Tnew stall and forwarding decisions plus mult/div scheduling
// that holds the front end while HI/LO results are outstanding.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic          clk,
   input  logic          reset,
   hazard_ctrl_if.slave  hz
);

   logic md_busy;
   logic md_done;
   logic data_stall;
   logic md_stall;

   md_sched #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_sched (
      .clk    (clk),
      .reset  (reset),
      .start  (hz.E_md_start),
      .is_div (hz.E_md_div),
      .busy   (md_busy),
      .done   (md_done)
   );

   always_comb begin
      data_stall = raw_stall(hz.D_rs_adr, hz.D_tuse_rs, hz.E_wr_adr, hz.E_tnew,
                             hz.M_wr_adr, hz.M_tnew) |
                   raw_stall(hz.D_rt_adr, hz.D_tuse_rt, hz.E_wr_adr, hz.E_tnew,
                             hz.M_wr_adr, hz.M_tnew);
      // HI/LO become readable the cycle after done, so the done cycle itself need not hold
      md_stall   = hz.D_md_use & (hz.E_md_start | (md_busy & ~md_done));
   end

   assign hz.stall    = data_stall | md_stall;
   assign hz.flush_E  = data_stall | md_stall;
   assign hz.fwd_D_rs = fwd_d_sel(hz.D_rs_adr, hz.E_wr_adr, hz.E_tnew, hz.M_wr_adr, hz.M_tnew);
   assign hz.fwd_D_rt = fwd_d_sel(hz.D_rt_adr, hz.E_wr_adr, hz.E_tnew, hz.M_wr_adr, hz.M_tnew);
   assign hz.fwd_E_rs = fwd_e_sel(hz.E_rs_adr, hz.M_wr_adr, hz.M_tnew, hz.W_wr_adr);
   assign hz.fwd_E_rt = fwd_e_sel(hz.E_rt_adr, hz.M_wr_adr, hz.M_tnew, hz.W_wr_adr);
   assign hz.md_busy  = md_busy;
   assign hz.md_done  = md_done;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic, checked against
// a cycle-window model of the mult/div unit and rule-level stall/forward functions.
module tb_hazard_ctrl;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_ctrl_if bus ();

   hazard_ctrl #(
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (bus)
   );

   typedef struct {
      logic       rst;
      logic [4:0] d_rs, d_rt;
      logic [1:0] tuse_rs, tuse_rt;
      logic       md_use;
      logic [4:0] e_wr;
      logic [1:0] e_tnew;
      logic [4:0] m_wr;
      logic [1:0] m_tnew;
      logic [4:0] w_wr, e_rs, e_rt;
      logic       start, is_div;
   } stim_t;

   typedef struct packed {
      logic       stall, flush;
      logic [1:0] fdrs, fdrt, fers, fert;
      logic       busy, done;
   } out_t;

   typedef struct {
      int   cyc;
      out_t exp;
   } sb_t;

   sb_t exp_q[$];
   int  n_checks = 0;
   int  n_pass   = 0;

   // Mult/div model: busy over the cycle window [md_beg, md_end], done at md_end
   int cyc    = 0;
   int md_beg = 1;
   int md_end = -1;

   function automatic bit m_busy(int c);
      return (c >= md_beg) && (c <= md_end);
   endfunction

   function automatic int not_ready(int adr, int tuse, int e, int et, int m, int mt);
      if (adr == 0 || tuse == 3) return 0;
      return ((adr == e && et > tuse) || (adr == m && mt > tuse)) ? 1 : 0;
   endfunction

   function automatic int src_d(int adr, int e, int et, int m, int mt);
      if (adr == 0) return 0;
      if (adr == e && et == 0) return 1;
      if (adr == m && mt == 0) return 2;
      return 0;
   endfunction

   function automatic int src_e(int adr, int m, int mt, int w);
      if (adr == 0) return 0;
      if (adr == m && mt == 0) return 1;
      if (adr == w) return 2;
      return 0;
   endfunction

   function automatic stim_t zero_stim();
      stim_t s;
      s = '{rst: 1'b0, d_rs: 5'd0, d_rt: 5'd0, tuse_rs: 2'd3, tuse_rt: 2'd3, md_use: 1'b0,
            e_wr: 5'd0, e_tnew: 2'd0, m_wr: 5'd0, m_tnew: 2'd0, w_wr: 5'd0, e_rs: 5'd0,
            e_rt: 5'd0, start: 1'b0, is_div: 1'b0};
      return s;
   endfunction

   task automatic drive(input stim_t s, input bit check);
      out_t e;
      bit   busy_now, done_now, dstall, mstall;
      @(posedge clk);
      #1;
      reset          = s.rst;
      bus.D_rs_adr   = s.d_rs;
      bus.D_rt_adr   = s.d_rt;
      bus.D_tuse_rs  = s.tuse_rs;
      bus.D_tuse_rt  = s.tuse_rt;
      bus.D_md_use   = s.md_use;
      bus.E_wr_adr   = s.e_wr;
      bus.E_tnew     = s.e_tnew;
      bus.M_wr_adr   = s.m_wr;
      bus.M_tnew     = s.m_tnew;
      bus.W_wr_adr   = s.w_wr;
      bus.E_rs_adr   = s.e_rs;
      bus.E_rt_adr   = s.e_rt;
      bus.E_md_start = s.start;
      bus.E_md_div   = s.is_div;
      if (check) begin
         busy_now = m_busy(cyc);
         done_now = (cyc == md_end) && !s.rst;
         dstall   = (not_ready(s.d_rs, s.tuse_rs, s.e_wr, s.e_tnew, s.m_wr, s.m_tnew) +
                     not_ready(s.d_rt, s.tuse_rt, s.e_wr, s.e_tnew, s.m_wr, s.m_tnew)) != 0;
         mstall   = s.md_use && (s.start || (busy_now && !done_now));
         e.stall  = dstall || mstall;
         e.flush  = dstall || mstall;
         e.fdrs   = 2'(src_d(s.d_rs, s.e_wr, s.e_tnew, s.m_wr, s.m_tnew));
         e.fdrt   = 2'(src_d(s.d_rt, s.e_wr, s.e_tnew, s.m_wr, s.m_tnew));
         e.fers   = 2'(src_e(s.e_rs, s.m_wr, s.m_tnew, s.w_wr));
         e.fert   = 2'(src_e(s.e_rt, s.m_wr, s.m_tnew, s.w_wr));
         e.busy   = busy_now;
         e.done   = done_now;
         exp_q.push_back('{cyc: cyc, exp: e});
      end
      if (s.rst) begin
         md_beg = 1;
         md_end = -1;
      end else if (s.start) begin
         md_beg = cyc + 1;
         md_end = cyc + (s.is_div ? DIV_N : MULT_N);
      end
      cyc++;
   endtask

   initial begin : monitor
      sb_t  item;
      out_t act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            item = exp_q.pop_front();
            act  = '{stall: bus.stall, flush: bus.flush_E, fdrs: bus.fwd_D_rs,
                     fdrt: bus.fwd_D_rt, fers: bus.fwd_E_rs, fert: bus.fwd_E_rt,
                     busy: bus.md_busy, done: bus.md_done};
            n_checks++;
            if (act === item.exp) begin
               n_pass++;
            end else begin
               $display("FAIL outputs cycle %0d: got stall=%b flush=%b fD=%0d/%0d fE=%0d/%0d busy=%b done=%b, want stall=%b flush=%b fD=%0d/%0d fE=%0d/%0d busy=%b done=%b",
                        item.cyc, act.stall, act.flush, act.fdrs, act.fdrt, act.fers, act.fert,
                        act.busy, act.done, item.exp.stall, item.exp.flush, item.exp.fdrs,
                        item.exp.fdrt, item.exp.fers, item.exp.fert, item.exp.busy,
                        item.exp.done);
            end
         end
      end
   end

   initial begin : stimulus
      stim_t s;
      bit    can_start;
      int    t;

      s = zero_stim();
      s.rst = 1'b1;
      drive(s, 1'b0);
      drive(s, 1'b1);
      drive(zero_stim(), 1'b1);

      // Load-use: E lw tnew 2 vs tuse 1, then in M with tnew 1, then in W
      s = zero_stim(); s.d_rs = 5'd8; s.tuse_rs = 2'd1; s.e_wr = 5'd8; s.e_tnew = 2'd2;
      drive(s, 1'b1);
      s = zero_stim(); s.d_rs = 5'd8; s.tuse_rs = 2'd1; s.m_wr = 5'd8; s.m_tnew = 2'd1;
      drive(s, 1'b1);
      s = zero_stim(); s.d_rs = 5'd8; s.tuse_rs = 2'd1; s.w_wr = 5'd8;
      drive(s, 1'b1);

      // Branch operands forwarded from M, then from E
      s = zero_stim(); s.d_rs = 5'd9; s.tuse_rs = 2'd0; s.m_wr = 5'd9; s.m_tnew = 2'd0;
      drive(s, 1'b1);
      s.e_wr = 5'd9; s.e_tnew = 2'd0;
      drive(s, 1'b1);

      // E operand: M beats W; then register $0 everywhere
      s = zero_stim(); s.e_rs = 5'd5; s.m_wr = 5'd5; s.m_tnew = 2'd0; s.w_wr = 5'd5;
      drive(s, 1'b1);
      s = zero_stim(); s.tuse_rs = 2'd0; s.tuse_rt = 2'd0; s.e_tnew = 2'd2; s.m_tnew = 2'd1;
      drive(s, 1'b1);

      // Mult with mflo waiting in D
      s = zero_stim(); s.md_use = 1'b1; s.start = 1'b1;
      drive(s, 1'b1);
      s = zero_stim(); s.md_use = 1'b1;
      repeat (7) drive(s, 1'b1);

      // Div aborted by reset on its fourth busy cycle
      s = zero_stim(); s.md_use = 1'b1; s.start = 1'b1; s.is_div = 1'b1;
      drive(s, 1'b1);
      s = zero_stim(); s.md_use = 1'b1;
      repeat (3) drive(s, 1'b1);
      s.rst = 1'b1;
      drive(s, 1'b1);
      s.rst = 1'b0;
      repeat (12) drive(s, 1'b1);

      // Back-to-back mult: second start lands in the done cycle
      s = zero_stim(); s.start = 1'b1;
      drive(s, 1'b1);
      s = zero_stim();
      repeat (MULT_N - 1) drive(s, 1'b1);
      s.start = 1'b1; s.md_use = 1'b1;
      drive(s, 1'b1);
      s = zero_stim(); s.md_use = 1'b1;
      repeat (MULT_N + 2) drive(s, 1'b1);

      // Random traffic; starts only when the unit is free or finishing
      for (int i = 0; i < 500; i++) begin
         s.rst     = ($urandom_range(0, 59) == 0);
         s.d_rs    = 5'($urandom_range(0, 3));
         s.d_rt    = 5'($urandom_range(0, 3));
         s.tuse_rs = 2'($urandom_range(0, 3));
         s.tuse_rt = 2'($urandom_range(0, 3));
         s.md_use  = ($urandom_range(0, 2) == 0);
         s.e_wr    = 5'($urandom_range(0, 3));
         s.e_tnew  = 2'($urandom_range(0, 2));
         s.m_wr    = 5'($urandom_range(0, 3));
         s.m_tnew  = 2'($urandom_range(0, 1));
         s.w_wr    = 5'($urandom_range(0, 3));
         s.e_rs    = 5'($urandom_range(0, 3));
         s.e_rt    = 5'($urandom_range(0, 3));
         s.is_div  = $urandom_range(0, 1) != 0;
         can_start = !m_busy(cyc) || (cyc == md_end);
         s.start   = can_start && ($urandom_range(0, 3) == 0);
         drive(s, 1'b1);
      end

      drive(zero_stim(), 1'b0);
      t = 0;
      while (exp_q.size() > 0 && t < 20) begin
         @(posedge clk);
         t++;
      end
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
